silpa_fpga_core: RTL and testbench

- Top-level FPGA block: an SPI slave (mode 0, MSB first) that exposes a small register bank controlling one 16-bit bidirectional GPIO "slot".
- Per-bit direction control, output latch, synchronized input readback, and masked change-interrupt with write-1-to-clear.
- Interrupt and status are shown on three user LEDs.
- All logic runs on the single system clock; SPI pins are oversampled.

---
 rtl/silpa_fpga_core_pkg.sv | 22 ++
 rtl/silpa_spi_slave.sv | 115 +++++++++++
 rtl/silpa_fpga_core.sv | 105 ++++++++++
 tb/tb_silpa_fpga_core.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/silpa_fpga_core_pkg.sv
// Shared definitions for the SPI-controlled GPIO slot: register map,
// command-field layout and SPI slave FSM states.
package silpa_fpga_core_pkg;

   localparam int REG_AW      = 7;
   localparam int RD_FLAG_BIT = 7;

   localparam logic [REG_AW-1:0] REG_OUT  = 7'h00;
   localparam logic [REG_AW-1:0] REG_IN   = 7'h08;
   localparam logic [REG_AW-1:0] REG_DIR  = 7'h10;
   localparam logic [REG_AW-1:0] REG_MASK = 7'h20;
   localparam logic [REG_AW-1:0] REG_CLR  = 7'h28;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_DONE
   } spi_state_t;

endpackage

// File: rtl/silpa_spi_slave.sv
// Oversampled mode-0 SPI slave: address, dummy and data phases, readback
// fetch during the dummy phase and a single-cycle write strobe.
module silpa_spi_slave
   import silpa_fpga_core_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 16,
   parameter int DUMMY_CYCLES = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sck,
   input  logic              mosi,
   input  logic              cs_n,
   output logic              miso,
   output logic              busy,
   output logic [ADDR_W-2:0] reg_addr,
   output logic [DATA_W-1:0] wdata,
   output logic              wr_strobe,
   output logic              rd_req,
   input  logic [DATA_W-1:0] rdata
);

   spi_state_t        state, state_next;
   logic [1:0]        sck_sync, mosi_sync, cs_sync;
   logic              sck_d;
   logic              sck_s, mosi_s, cs_s, sck_rise;
   logic [4:0]        bit_cnt;
   logic [ADDR_W-1:0] addr_sr;
   logic [DATA_W-1:0] rx_sr, tx_sr;
   logic              wr_q;

   // CS_n resets to its idle (high) level so the FSM stays in IDLE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         cs_sync   <= 2'b11;
         sck_d     <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[0], sck};
         mosi_sync <= {mosi_sync[0], mosi};
         cs_sync   <= {cs_sync[0], cs_n};
         sck_d     <= sck_s;
      end
   end

   assign sck_s    = sck_sync[1];
   assign mosi_s   = mosi_sync[1];
   assign cs_s     = cs_sync[1];
   assign sck_rise = sck_s & ~sck_d;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (!cs_s) state_next = ST_ADDR;
         ST_ADDR:  if (sck_rise && bit_cnt == 5'(ADDR_W - 1)) state_next = ST_DUMMY;
         ST_DUMMY: if (sck_rise && bit_cnt == 5'(DUMMY_CYCLES - 1)) state_next = ST_DATA;
         ST_DATA:  if (sck_rise && bit_cnt == 5'(DATA_W - 1)) state_next = ST_DONE;
         ST_DONE:  state_next = ST_DONE;
         default:  state_next = ST_IDLE;
      endcase
      if (cs_s) state_next = ST_IDLE;
   end

   // The shift register is reloaded every cycle of DUMMY so it holds the
   // freshest register value when the data phase begins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         addr_sr <= '0;
         rx_sr   <= '0;
         tx_sr   <= '0;
         wr_q    <= 1'b0;
      end else begin
         wr_q <= 1'b0;
         if (state != state_next) bit_cnt <= '0;
         else if (sck_rise)       bit_cnt <= bit_cnt + 5'd1;
         case (state)
            ST_ADDR:  if (sck_rise) addr_sr <= {addr_sr[ADDR_W-2:0], mosi_s};
            ST_DUMMY: tx_sr <= rdata;
            ST_DATA: begin
               if (sck_rise) begin
                  rx_sr <= {rx_sr[DATA_W-2:0], mosi_s};
                  tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                  if (state_next == ST_DONE && !addr_sr[RD_FLAG_BIT]) wr_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      miso = 1'b0;
      case (state)
         ST_ADDR:  miso = mosi;
         ST_DUMMY: miso = tx_sr[DATA_W-1];
         ST_DATA:  miso = tx_sr[DATA_W-1];
         default:  miso = 1'b0;
      endcase
   end

   assign busy      = ~cs_s;
   assign reg_addr  = addr_sr[ADDR_W-2:0];
   assign wdata     = rx_sr;
   assign wr_strobe = wr_q;
   assign rd_req    = (state == ST_DUMMY);

endmodule

// File: rtl/silpa_fpga_core.sv
// Top level: SPI-mapped register bank driving one 16-bit bidirectional
// GPIO slot with masked change interrupt and status LEDs.
module silpa_fpga_core
   import silpa_fpga_core_pkg::*;
#(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 16,
   parameter int DUMMY_CYCLES = 6,
   parameter int HB_DIV       = 24
) (
   input  logic              clk480,
   input  logic              sys_rst_n,
   input  logic              spi0_clk,
   input  logic              spi0_mosi,
   output logic              spi0_miso,
   input  logic              spi0_cs_n,
   inout  wire  [DATA_W-1:0] slot,
   output logic              user_led,
   output logic              user_led_1,
   output logic              user_led_2
);

   logic [ADDR_W-2:0] reg_addr;
   logic [DATA_W-1:0] wdata, rdata;
   logic              wr_strobe, rd_req;
   logic [DATA_W-1:0] out_reg, dir, mask, pending;
   logic [DATA_W-1:0] in_s1, in_s2, in_d;
   logic [DATA_W-1:0] chg, clr;
   logic [HB_DIV-1:0] hb_cnt;
   logic              led_q;

   silpa_spi_slave #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .DUMMY_CYCLES (DUMMY_CYCLES)
   ) u_spi (
      .clk       (clk480),
      .rst_n     (sys_rst_n),
      .sck       (spi0_clk),
      .mosi      (spi0_mosi),
      .cs_n      (spi0_cs_n),
      .miso      (spi0_miso),
      .busy      (user_led_2),
      .reg_addr  (reg_addr),
      .wdata     (wdata),
      .wr_strobe (wr_strobe),
      .rd_req    (rd_req),
      .rdata     (rdata)
   );

   for (genvar i = 0; i < DATA_W; i++) begin : g_pin
      assign slot[i] = dir[i] ? out_reg[i] : 1'bz;
   end

   // Only enabled, unmasked inputs flag a change; a same-cycle clear loses.
   assign chg = (in_s2 ^ in_d) & ~dir & mask;
   assign clr = (wr_strobe && reg_addr == REG_CLR) ? wdata : '0;

   always_ff @(posedge clk480) begin
      if (!sys_rst_n) begin
         out_reg <= '0;
         dir     <= '0;
         mask    <= '0;
         pending <= '0;
         in_s1   <= '0;
         in_s2   <= '0;
         in_d    <= '0;
         hb_cnt  <= '0;
         led_q   <= 1'b0;
      end else begin
         in_s1   <= slot;
         in_s2   <= in_s1;
         in_d    <= in_s2;
         hb_cnt  <= hb_cnt + 1'b1;
         led_q   <= |pending;
         pending <= (pending & ~clr) | chg;
         if (wr_strobe) begin
            case (reg_addr)
               REG_OUT:  out_reg <= wdata;
               REG_DIR:  dir     <= wdata;
               REG_MASK: mask    <= wdata;
               default:  ;
            endcase
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (rd_req) begin
         case (reg_addr)
            REG_OUT:  rdata = out_reg;
            REG_IN:   rdata = in_s2;
            REG_DIR:  rdata = dir;
            REG_MASK: rdata = mask;
            REG_CLR:  rdata = pending;
            default:  rdata = '0;
         endcase
      end
   end

   assign user_led   = led_q;
   assign user_led_1 = hb_cnt[HB_DIV-1];

endmodule

// File: tb/tb_silpa_fpga_core.sv
// Self-checking bench for silpa_fpga_core: table of SPI transactions with
// expected readback, pin and LED values, plus abort, reset and heartbeat cases.
module tb_silpa_fpga_core;
   import silpa_fpga_core_pkg::*;

   localparam int HALF = 4;

   logic        clk = 1'b0;
   logic        rst_n, sck, mosi, cs_n;
   logic        miso, led0, led1, led2;
   logic [15:0] tb_oe, tb_drv;
   wire  [15:0] slot;

   always #5 clk = ~clk;

   for (genvar i = 0; i < 16; i++) begin : g_ext
      assign slot[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
   end

   silpa_fpga_core #(.HB_DIV(6)) dut (
      .clk480     (clk),
      .sys_rst_n  (rst_n),
      .spi0_clk   (sck),
      .spi0_mosi  (mosi),
      .spi0_miso  (miso),
      .spi0_cs_n  (cs_n),
      .slot       (slot),
      .user_led   (led0),
      .user_led_1 (led1),
      .user_led_2 (led2)
   );

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] oe;
      logic [15:0] drv;
      logic        chk_rd;
      logic [15:0] exp_rd;
      logic        chk_slot;
      logic [15:0] exp_slot;
      logic        chk_led;
      logic        exp_led;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        busy_seen;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bit(input logic b, output logic m);
      mosi = b;
      clks(HALF);
      m = miso;
      sck = 1'b1;
      clks(HALF);
      sck = 1'b0;
   endtask

   task automatic spi_xfer(input logic [7:0] a, input logic [15:0] d, input int nbits,
                           output logic [7:0] echo, output logic [15:0] rd);
      logic m;
      echo = '0;
      rd   = '0;
      cs_n = 1'b0;
      clks(4);
      busy_seen = led2;
      for (int i = 0; i < 8; i++) begin
         spi_bit(a[7-i], m);
         echo[7-i] = m;
      end
      for (int i = 0; i < 6; i++) spi_bit(1'b0, m);
      for (int i = 0; i < nbits; i++) begin
         spi_bit(d[15-i], m);
         rd[15-i] = m;
      end
      clks(HALF);
      cs_n = 1'b1;
      mosi = 1'b0;
      clks(6);
   endtask

   task automatic read_chk(input string name, input logic [7:0] a, input logic [15:0] exp);
      logic [7:0]  echo;
      logic [15:0] rd;
      exp_q.push_back(exp);
      spi_xfer(a, 16'h0000, 16, echo, rd);
      check({name, "_echo"}, {8'h00, echo}, {8'h00, a});
      check(name, rd, exp_q.pop_front());
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [15:0] d);
      logic [7:0]  echo;
      logic [15:0] rd;
      spi_xfer(a, d, 16, echo, rd);
   endtask

   task automatic add(input logic [7:0] a, input logic [15:0] wd, input logic [15:0] oe,
                      input logic [15:0] drv, input logic [15:0] rd, input logic cs,
                      input logic [15:0] sl, input logic cl, input logic ld);
      vec_t v;
      v.addr = a;  v.wdata = wd;  v.oe = oe;  v.drv = drv;
      v.chk_rd = 1'b1;  v.exp_rd = rd;
      v.chk_slot = cs;  v.exp_slot = sl;
      v.chk_led = cl;   v.exp_led = ld;
      vecs.push_back(v);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [7:0]  echo;
      logic [15:0] rd;
      tb_oe  = v.oe;
      tb_drv = v.drv;
      clks(8);
      if (v.chk_rd) exp_q.push_back(v.exp_rd);
      spi_xfer(v.addr, v.wdata, 16, echo, rd);
      check($sformatf("v%0d_echo", idx), {8'h00, echo}, {8'h00, v.addr});
      if (v.chk_rd)   check($sformatf("v%0d_rd", idx), rd, exp_q.pop_front());
      if (v.chk_slot) check($sformatf("v%0d_slot", idx), slot, v.exp_slot);
      if (v.chk_led)  check($sformatf("v%0d_led", idx), {15'h0, led0}, {15'h0, v.exp_led});
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic m;
      int   hi;
      rst_n = 1'b0;  sck = 1'b0;  mosi = 1'b0;  cs_n = 1'b1;
      tb_oe = '0;    tb_drv = '0;

      //  addr   wdata    oe       drv      rd       chk slot     chk led
      add(8'h01, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
      add(8'h10, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0);
      add(8'h00, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1, 16'h1234, 0, 0);
      add(8'h88, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 1, 16'h1234, 0, 0);
      add(8'h80, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 0, 16'h0000, 0, 0);
      add(8'h81, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
      add(8'h10, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 0, 16'h0000, 0, 0);
      add(8'h88, 16'h0000, 16'hFFFF, 16'h5555, 16'h5555, 1, 16'h5555, 0, 0);
      add(8'h88, 16'h0000, 16'hFFFF, 16'hAAAA, 16'hAAAA, 1, 16'hAAAA, 0, 0);
      add(8'h00, 16'hAAAA, 16'hFFFF, 16'h5555, 16'h1234, 1, 16'h5555, 0, 0);
      add(8'h10, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1, 16'hAAAA, 0, 0);
      add(8'h10, 16'h00FF, 16'h0000, 16'h0000, 16'hFFFF, 0, 16'h0000, 0, 0);
      add(8'h88, 16'h0000, 16'hFF00, 16'h5500, 16'h55AA, 1, 16'h55AA, 0, 0);
      add(8'h90, 16'h0000, 16'hFF00, 16'h5500, 16'h00FF, 1, 16'h55AA, 0, 0);
      add(8'h80, 16'h1234, 16'hFF00, 16'h5500, 16'hAAAA, 1, 16'h55AA, 0, 0);
      add(8'h80, 16'h0000, 16'hFF00, 16'h5500, 16'hAAAA, 1, 16'h55AA, 0, 0);
      add(8'h45, 16'hFFFF, 16'hFF00, 16'h5500, 16'h0000, 1, 16'h55AA, 0, 0);
      add(8'hC5, 16'h0000, 16'hFF00, 16'h5500, 16'h0000, 0, 16'h0000, 0, 0);
      add(8'h90, 16'h0000, 16'hFF00, 16'h5500, 16'h00FF, 0, 16'h0000, 0, 0);
      add(8'h10, 16'h0000, 16'hFF00, 16'h0000, 16'h00FF, 0, 16'h0000, 0, 0);
      add(8'h20, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1, 16'h0000, 1, 0);
      add(8'hA8, 16'h0000, 16'hFFFF, 16'h0001, 16'h0001, 1, 16'h0001, 1, 1);
      add(8'h28, 16'h0001, 16'hFFFF, 16'h0001, 16'h0001, 0, 16'h0000, 1, 0);
      add(8'h20, 16'hFFFE, 16'hFFFF, 16'h0001, 16'hFFFF, 0, 16'h0000, 1, 0);
      add(8'hA8, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0);
      add(8'hA8, 16'h0000, 16'hFFFF, 16'h0002, 16'h0002, 0, 16'h0000, 1, 1);
      add(8'h28, 16'hFFFF, 16'hFFFF, 16'h0002, 16'h0002, 0, 16'h0000, 1, 0);

      // Reset values
      clks(4);
      check("rst_miso",  {15'h0, miso}, 16'h0000);
      check("rst_led",   {15'h0, led0}, 16'h0000);
      check("rst_hb",    {15'h0, led1}, 16'h0000);
      check("rst_busy",  {15'h0, led2}, 16'h0000);
      check("rst_state", 16'(dut.u_spi.state), 16'(ST_IDLE));
      rst_n = 1'b1;
      clks(4);
      tb_oe = 16'hFFFF;  tb_drv = 16'h9C9C;
      clks(2);
      check("rst_slot_z", slot, 16'h9C9C);
      tb_oe = '0;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // Abort after five data bits leaves out_reg alone
      begin
         logic [7:0]  echo;
         logic [15:0] rd;
         spi_xfer(8'h00, 16'h1234, 5, echo, rd);
      end
      check("busy_in_xfer", {15'h0, busy_seen}, 16'h0001);
      check("busy_idle", {15'h0, led2}, 16'h0000);
      read_chk("abort_keep", 8'h80, 16'hAAAA);
      write_reg(8'h00, 16'h0F0F);
      read_chk("after_abort", 8'h80, 16'h0F0F);

      // Reset in the middle of an address phase
      tb_oe = '0;
      clks(4);
      write_reg(8'h10, 16'hFFFF);
      write_reg(8'h20, 16'hFFFF);
      check("pre_rst_slot", slot, 16'h0F0F);
      cs_n = 1'b0;
      clks(4);
      for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
      mosi = 1'b1;
      clks(HALF);
      sck = 1'b1;
      rst_n = 1'b0;
      clks(3);
      check("mid_rst_state", 16'(dut.u_spi.state), 16'(ST_IDLE));
      check("mid_rst_miso",  {15'h0, miso}, 16'h0000);
      check("mid_rst_led",   {15'h0, led0}, 16'h0000);
      check("mid_rst_busy",  {15'h0, led2}, 16'h0000);
      sck = 1'b0;  cs_n = 1'b1;  mosi = 1'b0;
      tb_oe = 16'hFFFF;  tb_drv = 16'h3C3C;
      clks(2);
      rst_n = 1'b1;
      clks(4);
      check("post_rst_slot", slot, 16'h3C3C);
      read_chk("post_rst_out",  8'h80, 16'h0000);
      read_chk("post_rst_dir",  8'h90, 16'h0000);
      read_chk("post_rst_mask", 8'hA0, 16'h0000);
      read_chk("post_rst_pend", 8'hA8, 16'h0000);
      read_chk("post_rst_in",   8'h88, 16'h3C3C);

      // Heartbeat MSB of a 6-bit counter is high half of any 64-cycle window
      hi = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (led1) hi++;
      end
      check("heartbeat_duty", 16'(hi), 16'd32);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
